// File: rtl/fsk_frame_tx_if.sv
// Word handshake between the coded-word source and the FSK framing serializer.
interface fsk_frame_tx_if #(
    parameter int WORD_W = 12
);
    logic              valid;
    logic              ready;
    logic [WORD_W-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/fsk_frame_tx.sv
// Framing serializer: prepends SYNC_PAT to every WORDS_PER_FRAME coded words and
// emits one bit per DIV sysclk cycles, substituting FILL_WORD when the source runs dry.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | line at mark (1), waiting for en and a held word
// ST_SYNC | shifting out SYNC_W bits of SYNC_PAT, MSB first
// ST_DATA | shifting out WORDS_PER_FRAME words of WORD_W bits, MSB first
module fsk_frame_tx #(
    parameter int                 WORD_W          = 12,
    parameter int                 WORDS_PER_FRAME = 4,
    parameter int                 SYNC_W          = 8,
    parameter logic [SYNC_W-1:0]  SYNC_PAT        = 8'hA5,
    parameter logic [WORD_W-1:0]  FILL_WORD       = '0,
    parameter int                 DIV             = 16
) (
    input  logic           sysclk,
    input  logic           reset,
    input  logic           en,
    fsk_frame_tx_if.slave  in_if,
    output logic           bit_out,
    output logic           bit_strobe,
    output logic           frame_start,
    output logic           busy,
    output logic           underrun
);
    localparam int BC_MAX = (SYNC_W > WORD_W) ? SYNC_W : WORD_W;
    localparam int BC_W   = $clog2(BC_MAX);
    localparam int WC_W   = (WORDS_PER_FRAME > 1) ? $clog2(WORDS_PER_FRAME) : 1;
    localparam int TM_W   = $clog2(DIV);

    localparam logic [TM_W-1:0] TM_LAST    = TM_W'(DIV - 1);
    localparam logic [BC_W-1:0] SYNC_LAST  = BC_W'(SYNC_W - 1);
    localparam logic [BC_W-1:0] WORD_LAST  = BC_W'(WORD_W - 1);
    localparam logic [WC_W-1:0] FRAME_LAST = WC_W'(WORDS_PER_FRAME - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SYNC,
        ST_DATA
    } state_t;

    state_t             state_q, state_d;
    logic [TM_W-1:0]    timer_q, timer_d;
    logic [BC_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [WC_W-1:0]    word_cnt_q, word_cnt_d;
    logic [SYNC_W-1:0]  sync_sr_q, sync_sr_d;
    logic [WORD_W-1:0]  data_sr_q, data_sr_d;
    logic               hold_full_q, hold_full_d;
    logic [WORD_W-1:0]  hold_data_q, hold_data_d;
    logic               ready_q, ready_d;
    logic               bit_out_d, bit_strobe_d, frame_start_d, busy_d, underrun_d;

    logic accept, period_end, can_start, start, load;

    assign in_if.ready = ready_q;

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            bit_cnt_q   <= '0;
            word_cnt_q  <= '0;
            sync_sr_q   <= '0;
            data_sr_q   <= '0;
            hold_full_q <= 1'b0;
            hold_data_q <= '0;
            ready_q     <= 1'b1;
            bit_out     <= 1'b1;
            bit_strobe  <= 1'b0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            bit_cnt_q   <= bit_cnt_d;
            word_cnt_q  <= word_cnt_d;
            sync_sr_q   <= sync_sr_d;
            data_sr_q   <= data_sr_d;
            hold_full_q <= hold_full_d;
            hold_data_q <= hold_data_d;
            ready_q     <= ready_d;
            bit_out     <= bit_out_d;
            bit_strobe  <= bit_strobe_d;
            frame_start <= frame_start_d;
            busy        <= busy_d;
            underrun    <= underrun_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        bit_cnt_d     = bit_cnt_q;
        word_cnt_d    = word_cnt_q;
        sync_sr_d     = sync_sr_q;
        data_sr_d     = data_sr_q;
        hold_full_d   = hold_full_q;
        hold_data_d   = hold_data_q;
        bit_out_d     = bit_out;
        bit_strobe_d  = 1'b0;
        frame_start_d = 1'b0;
        underrun_d    = 1'b0;
        start         = 1'b0;
        load          = 1'b0;

        accept     = in_if.valid && ready_q;
        period_end = (timer_q == TM_LAST);
        // A word accepted on this edge counts as held, so a frame can start immediately.
        can_start  = en && (hold_full_q || accept);

        if (accept) begin
            hold_full_d = 1'b1;
            hold_data_d = in_if.data;
        end

        case (state_q)
            ST_IDLE: begin
                bit_out_d = 1'b1;
                timer_d   = '0;
                if (can_start) start = 1'b1;
            end
            ST_SYNC: begin
                timer_d = timer_q + TM_W'(1);
                if (period_end) begin
                    timer_d      = '0;
                    bit_strobe_d = 1'b1;
                    if (bit_cnt_q == SYNC_LAST) begin
                        state_d    = ST_DATA;
                        bit_cnt_d  = '0;
                        word_cnt_d = '0;
                        load       = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BC_W'(1);
                        sync_sr_d = sync_sr_q << 1;
                        bit_out_d = sync_sr_q[SYNC_W-2];
                    end
                end
            end
            ST_DATA: begin
                timer_d = timer_q + TM_W'(1);
                if (period_end) begin
                    timer_d      = '0;
                    bit_strobe_d = 1'b1;
                    if (bit_cnt_q == WORD_LAST) begin
                        bit_cnt_d = '0;
                        if (word_cnt_q == FRAME_LAST) begin
                            if (can_start) begin
                                start = 1'b1;
                            end else begin
                                state_d      = ST_IDLE;
                                bit_out_d    = 1'b1;
                                bit_strobe_d = 1'b0;
                            end
                        end else begin
                            word_cnt_d = word_cnt_q + WC_W'(1);
                            load       = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + BC_W'(1);
                        data_sr_d = data_sr_q << 1;
                        bit_out_d = data_sr_q[WORD_W-2];
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (start) begin
            state_d       = ST_SYNC;
            timer_d       = '0;
            bit_cnt_d     = '0;
            word_cnt_d    = '0;
            sync_sr_d     = SYNC_PAT;
            bit_out_d     = SYNC_PAT[SYNC_W-1];
            bit_strobe_d  = 1'b1;
            frame_start_d = 1'b1;
        end

        // The load takes the old holding word; a same-cycle accept refills the register.
        if (load) begin
            if (hold_full_q) begin
                data_sr_d   = hold_data_q;
                bit_out_d   = hold_data_q[WORD_W-1];
                hold_full_d = accept;
            end else begin
                data_sr_d  = FILL_WORD;
                bit_out_d  = FILL_WORD[WORD_W-1];
                underrun_d = 1'b1;
            end
        end

        busy_d  = (state_d != ST_IDLE);
        ready_d = ~hold_full_d;
    end
endmodule

// File: tb/tb_fsk_frame_tx.sv
// Directed bench for fsk_frame_tx at default parameters (DIV=16, 896-cycle frames).
module tb_fsk_frame_tx;
    logic sysclk = 1'b0;
    logic reset  = 1'b1;
    logic en     = 1'b0;
    logic bit_out, bit_strobe, frame_start, busy, underrun;

    fsk_frame_tx_if #(.WORD_W(12)) in_if ();

    fsk_frame_tx dut (
        .sysclk      (sysclk),
        .reset       (reset),
        .en          (en),
        .in_if       (in_if),
        .bit_out     (bit_out),
        .bit_strobe  (bit_strobe),
        .frame_start (frame_start),
        .busy        (busy),
        .underrun    (underrun)
    );

    always #5 sysclk = ~sysclk;

    int total = 0;
    int bad   = 0;

    // Event log sampled on the falling edge.
    int   cyc = 0, n_strobe = 0, n_fs = 0, n_ur = 0, n_fall = 0;
    int   fs_last = 0, fs_prev = 0, fall_cyc = 0, ur_lone = 0;
    logic busy_prev = 1'b0;
    logic bitlog [0:1023];
    int   ur_pos [0:15];

    always @(negedge sysclk) begin
        cyc       <= cyc + 1;
        busy_prev <= busy;
        if (bit_strobe) begin
            if (n_strobe < 1024) bitlog[n_strobe] <= bit_out;
            n_strobe <= n_strobe + 1;
        end
        if (frame_start) begin
            fs_prev <= fs_last;
            fs_last <= cyc;
            n_fs    <= n_fs + 1;
        end
        if (underrun) begin
            if (n_ur < 16) ur_pos[n_ur] <= n_strobe;
            n_ur <= n_ur + 1;
            if (!bit_strobe) ur_lone <= ur_lone + 1;
        end
        if (busy_prev && !busy) begin
            fall_cyc <= cyc;
            n_fall   <= n_fall + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic frame_bits(input int start, input int n, output logic [63:0] v);
        v = '0;
        for (int i = 0; i < n; i++) v = {v[62:0], bitlog[start+i]};
    endtask

    // Present a word and return on the falling edge right after it was accepted.
    task automatic push(input logic [11:0] w);
        int n = 0;
        in_if.valid = 1'b1;
        in_if.data  = w;
        while (!in_if.ready && n < 3000) begin
            @(negedge sysclk);
            n++;
        end
        chk("push_ready_timeout", {63'd0, in_if.ready}, 64'd1);
        @(negedge sysclk);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 5000) begin
            @(negedge sysclk);
            n++;
        end
        chk("idle_timeout", {63'd0, busy}, 64'd0);
        #1;
    endtask

    logic [63:0] v;
    int s0, f0, u0, d0, fs_a;

    initial begin
        in_if.valid = 1'b1;
        in_if.data  = 12'hFFF;
        en          = 1'b1;

        // Reset held with a word offered
        repeat (5) @(negedge sysclk);
        chk("rst_in_ready", {63'd0, in_if.ready}, 64'd1);
        chk("rst_bit_out",  {63'd0, bit_out}, 64'd1);
        chk("rst_busy",     {63'd0, busy}, 64'd0);
        chk("rst_pulses",   {61'd0, bit_strobe, frame_start, underrun}, 64'd0);
        in_if.valid = 1'b0;
        en          = 1'b0;
        reset       = 1'b0;
        repeat (3) @(negedge sysclk);
        chk("post_rst_ready", {63'd0, in_if.ready}, 64'd1);
        chk("post_rst_busy",  {63'd0, busy}, 64'd0);
        #1;

        // Full frame, four words
        en = 1'b1;
        s0 = n_strobe; f0 = n_fs; u0 = n_ur;
        push(12'hABC);
        in_if.valid = 1'b0;
        chk("t2_frame_start", {63'd0, frame_start}, 64'd1);
        chk("t2_strobe",      {63'd0, bit_strobe}, 64'd1);
        chk("t2_busy",        {63'd0, busy}, 64'd1);
        chk("t2_first_bit",   {63'd0, bit_out}, 64'd1);
        chk("t2_ready_low",   {63'd0, in_if.ready}, 64'd0);
        repeat (127) @(negedge sysclk);
        chk("t2_ready_before_load", {63'd0, in_if.ready}, 64'd0);
        @(negedge sysclk);
        chk("t2_ready_after_load",  {63'd0, in_if.ready}, 64'd1);
        push(12'h123);
        push(12'h456);
        push(12'h789);
        in_if.valid = 1'b0;
        wait_idle();
        frame_bits(s0, 56, v);
        chk("t2_bits",      v, 64'h00A5ABC123456789);
        chk("t2_strobes",   64'(n_strobe - s0), 64'd56);
        chk("t2_fs_count",  64'(n_fs - f0), 64'd1);
        chk("t2_underruns", 64'(n_ur - u0), 64'd0);
        chk("t2_busy_len",  64'(fall_cyc - fs_last), 64'd896);

        // Single word: three fill words
        s0 = n_strobe; u0 = n_ur;
        push(12'hABC);
        in_if.valid = 1'b0;
        wait_idle();
        frame_bits(s0, 56, v);
        chk("t3_bits",       v, 64'h00A5ABC000000000);
        chk("t3_underruns",  64'(n_ur - u0), 64'd3);
        chk("t3_ur_pos",     {16'd0, 16'(ur_pos[u0] - s0), 16'(ur_pos[u0+1] - s0), 16'(ur_pos[u0+2] - s0)},
                             {16'd0, 16'd20, 16'd32, 16'd44});
        chk("t3_ur_lone",    64'(ur_lone), 64'd0);
        chk("t3_busy_len",   64'(fall_cyc - fs_last), 64'd896);

        // Continuous stream: two frames back to back
        s0 = n_strobe; f0 = n_fs; u0 = n_ur; d0 = n_fall;
        push(12'h111); push(12'h222); push(12'h333); push(12'h444);
        push(12'h555); push(12'h666); push(12'h777); push(12'h888);
        in_if.valid = 1'b0;
        wait_idle();
        frame_bits(s0, 56, v);
        chk("t4_bits_f1",   v, 64'h00A5111222333444);
        frame_bits(s0 + 56, 56, v);
        chk("t4_bits_f2",   v, 64'h00A5555666777888);
        chk("t4_fs_count",  64'(n_fs - f0), 64'd2);
        chk("t4_fs_gap",    64'(fs_last - fs_prev), 64'd896);
        chk("t4_busy_falls", 64'(n_fall - d0), 64'd1);
        chk("t4_busy_len",  64'(fall_cyc - fs_prev), 64'd1792);
        chk("t4_underruns", 64'(n_ur - u0), 64'd0);

        // en drops mid-frame with the next word already held
        s0 = n_strobe; f0 = n_fs;
        push(12'hF0F);
        in_if.valid = 1'b0;
        repeat (99) @(negedge sysclk);
        en = 1'b0;
        push(12'h0F0); push(12'h3C3); push(12'hC3C); push(12'h9A6);
        in_if.valid = 1'b0;
        wait_idle();
        frame_bits(s0, 56, v);
        chk("t5_bits",       v, 64'h00A5F0F0F03C3C3C);
        chk("t5_busy_len",   64'(fall_cyc - fs_last), 64'd896);
        repeat (50) @(negedge sysclk);
        chk("t5_still_idle", {63'd0, busy}, 64'd0);
        chk("t5_word_held",  {63'd0, in_if.ready}, 64'd0);
        #1;
        chk("t5_no_restart", 64'(n_fs - f0), 64'd1);
        s0 = n_strobe;
        en = 1'b1;
        @(negedge sysclk);
        chk("t5_restart_fs", {63'd0, frame_start}, 64'd1);
        wait_idle();
        frame_bits(s0, 20, v);
        chk("t5_restart_bits", v, 64'h00000000000A59A6);

        // Asynchronous reset at cycle 300 of a frame
        push(12'hABC);
        in_if.valid = 1'b0;
        repeat (299) @(negedge sysclk);
        chk("t6_pre_bit",  {63'd0, bit_out}, 64'd0);
        chk("t6_pre_busy", {63'd0, busy}, 64'd1);
        #2 reset = 1'b1;
        #1;
        chk("t6_rst_bit_out", {63'd0, bit_out}, 64'd1);
        chk("t6_rst_ready",   {63'd0, in_if.ready}, 64'd1);
        chk("t6_rst_busy",    {63'd0, busy}, 64'd0);
        chk("t6_rst_pulses",  {61'd0, bit_strobe, frame_start, underrun}, 64'd0);
        repeat (2) @(negedge sysclk);
        reset = 1'b0;
        repeat (3) @(negedge sysclk);
        chk("t6_post_busy", {63'd0, busy}, 64'd0);
        #1;
        s0 = n_strobe; u0 = n_ur;
        push(12'h5A5);
        in_if.valid = 1'b0;
        chk("t6_fs", {63'd0, frame_start}, 64'd1);
        wait_idle();
        frame_bits(s0, 56, v);
        chk("t6_bits",      v, 64'h00A55A5000000000);
        chk("t6_underruns", 64'(n_ur - u0), 64'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end
endmodule
